// File: rtl/ap_ctrl_pkg.sv
// ap_ctrl_pkg: shared FSM state encoding and default widths for the
// ap_ctrl_hs launcher and its timestamp FIFO.
package ap_ctrl_pkg;

   localparam int CNT_W_DEF   = 16;
   localparam int MAX_OUT_DEF = 4;
   localparam int LAT_W_DEF   = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_FINISH = 2'd3
   } ap_state_e;

endpackage

// File: rtl/ap_ts_fifo.sv
// ap_ts_fifo: issue-timestamp FIFO for the launcher latency statistics.
// Only compiled when AP_CTRL_LAT_STATS_EN is defined. The head entry is read
// combinationally so a push and a pop can share a cycle, including when full.
`ifdef AP_CTRL_LAT_STATS_EN
module ap_ts_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] r_mem [2**PTR_W];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;

   // Timestamp storage; contents need no reset, the pointers define validity.
   always_ff @(posedge i_clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   // Circular pointers that wrap at DEPTH-1 so any DEPTH in 1..16 works.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + PTR_W'(1);
         end
         if (i_pop) begin
            r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + PTR_W'(1);
         end
      end
   end

   assign o_dout = r_mem[r_rd_ptr];

endmodule
`endif

// File: rtl/ap_ctrl_launcher.sv
// ap_ctrl_launcher: initiator side of the ap_ctrl_hs handshake. Issues a
// commanded number of kernel invocations with at most MAX_OUT outstanding,
// counts completions and raises a level finish.
// Optional macro AP_CTRL_LAT_STATS_EN adds start-to-done latency statistics;
// without it last_latency/max_latency are tied to 0.
module ap_ctrl_launcher
   import ap_ctrl_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int MAX_OUT = MAX_OUT_DEF,
   parameter int LAT_W   = LAT_W_DEF
`ifdef AP_CTRL_LAT_STATS_EN
   ,
   // Reset value of the free-running cycle counter.
   parameter logic [LAT_W-1:0] TS_INIT = '0
`endif
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CNT_W-1:0] cmd_count,
   output logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   output logic             ap_continue,
   output logic             busy,
   output logic             finish,
   output logic [CNT_W-1:0] issued_cnt,
   output logic [CNT_W-1:0] done_cnt,
   output logic             err_unexp_done,
   output logic [LAT_W-1:0] last_latency,
   output logic [LAT_W-1:0] max_latency
);

   localparam int OUT_W = $clog2(MAX_OUT + 1);
   localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);

   ap_state_e        r_state;
   ap_state_e        w_state_next;
   logic             r_start;
   logic             w_start_next;
   logic             r_cont;
   logic             r_cmd_ready;
   logic             r_busy;
   logic             r_finish;
   logic             r_err;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_issued;
   logic [CNT_W-1:0] r_done;
   logic [CNT_W-1:0] w_issued_next;
   logic [CNT_W-1:0] w_done_next;
   logic [OUT_W-1:0] r_out;
   logic [OUT_W-1:0] w_out_next;
   logic             w_accept;
   logic             w_issue;
   logic             w_done_evt;
   logic             w_running;
   logic             w_done_cnt;
   logic             w_done_unexp;

   assign w_accept     = cmd_valid & r_cmd_ready;
   assign w_issue      = r_start & ap_ready;
   assign w_done_evt   = ap_done & r_cont;
   assign w_running    = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
   // A completion only counts against an invocation actually in flight.
   assign w_done_cnt   = w_done_evt & w_running & (r_out != '0);
   assign w_done_unexp = w_done_evt & ~w_done_cnt;

   // Next-state, counter and registered-start computation.
   always_comb begin
      w_issued_next = r_issued + CNT_W'(w_issue);
      w_done_next   = r_done + CNT_W'(w_done_cnt);
      w_out_next    = r_out;
      if (w_issue && !w_done_cnt) begin
         w_out_next = r_out + OUT_W'(1);
      end else if (!w_issue && w_done_cnt) begin
         w_out_next = r_out - OUT_W'(1);
      end
      w_state_next = r_state;
      w_start_next = 1'b0;
      case (r_state)
         ST_IDLE, ST_FINISH: begin
            if (w_accept) begin
               w_issued_next = '0;
               w_done_next   = '0;
               w_out_next    = '0;
               if (cmd_count != '0) begin
                  w_state_next = ST_ISSUE;
                  w_start_next = 1'b1;
               end else begin
                  w_state_next = ST_FINISH;
               end
            end
         end
         ST_ISSUE: begin
            // Start never drops while waiting for ready: without an issue the
            // outstanding count can only fall, so the condition keeps holding.
            if (w_issued_next == r_count) begin
               w_state_next = ST_DRAIN;
            end else begin
               w_start_next = (w_out_next < MAX_OUT_C);
            end
         end
         ST_DRAIN: begin
            if (w_done_next == r_count) begin
               w_state_next = ST_FINISH;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Control state, handshake outputs and run counters.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state     <= ST_IDLE;
         r_start     <= 1'b0;
         r_cont      <= 1'b0;
         r_cmd_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_finish    <= 1'b0;
         r_err       <= 1'b0;
         r_count     <= '0;
         r_issued    <= '0;
         r_done      <= '0;
         r_out       <= '0;
      end else begin
         r_state     <= w_state_next;
         r_start     <= w_start_next;
         r_cont      <= 1'b1;
         r_cmd_ready <= (w_state_next == ST_IDLE) || (w_state_next == ST_FINISH);
         r_busy      <= (w_state_next == ST_ISSUE) || (w_state_next == ST_DRAIN);
         r_finish    <= (w_state_next == ST_FINISH);
         r_issued    <= w_issued_next;
         r_done      <= w_done_next;
         r_out       <= w_out_next;
         if (w_accept) begin
            r_count <= cmd_count;
         end
         if (w_done_unexp) begin
            r_err <= 1'b1;
         end
      end
   end

   assign cmd_ready      = r_cmd_ready;
   assign ap_start       = r_start;
   assign ap_continue    = r_cont;
   assign busy           = r_busy;
   assign finish         = r_finish;
   assign issued_cnt     = r_issued;
   assign done_cnt       = r_done;
   assign err_unexp_done = r_err;

`ifdef AP_CTRL_LAT_STATS_EN
   logic [LAT_W-1:0] r_timer;
   logic [LAT_W-1:0] w_ts_head;
   logic [LAT_W-1:0] w_lat;
   logic [LAT_W-1:0] r_last_lat;
   logic [LAT_W-1:0] r_max_lat;

   // Free-running cycle counter; modular subtraction absorbs its wrap.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_timer <= TS_INIT;
      end else begin
         r_timer <= r_timer + LAT_W'(1);
      end
   end

   ap_ts_fifo #(
      .DEPTH (MAX_OUT),
      .WIDTH (LAT_W)
   ) u_ts_fifo (
      .i_clk   (ap_clk),
      .i_rst_n (ap_rst_n),
      .i_push  (w_issue),
      .i_din   (r_timer),
      .i_pop   (w_done_cnt),
      .o_dout  (w_ts_head)
   );

   assign w_lat = r_timer - w_ts_head;

   // Latency of each counted completion and the running maximum per run.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_last_lat <= '0;
         r_max_lat  <= '0;
      end else if (w_accept) begin
         r_max_lat <= '0;
      end else if (w_done_cnt) begin
         r_last_lat <= w_lat;
         if (w_lat > r_max_lat) begin
            r_max_lat <= w_lat;
         end
      end
   end

   assign last_latency = r_last_lat;
   assign max_latency  = r_max_lat;
`else
   assign last_latency = '0;
   assign max_latency  = '0;
`endif

endmodule
